// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execution endpoint.
//   - opcode class codes (issue_opt[5:3]) and funct codes (issue_opt[2:0])
//   - data / ROB-tag widths, RS "no-dependency" tag value
//   - CDB entry struct and operand-B selection helper
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OPT_W  = 6;

  // Tag value the RS uses to mark an operand as already available.
  localparam logic [4:0] NO_DEP_TAG = 5'd16;

  typedef enum logic [2:0] {
    CLS_RR   = 3'b000,
    CLS_RSUB = 3'b001,
    CLS_RI   = 3'b010,
    CLS_RISH = 3'b011,
    CLS_BR   = 3'b100,
    CLS_RSV5 = 3'b101,
    CLS_RSV6 = 3'b110,
    CLS_RSV7 = 3'b111
  } alu_cls_e;

  // Register/immediate integer functs (classes 000/010)
  localparam logic [2:0] FN_ADD  = 3'd0;
  localparam logic [2:0] FN_SLL  = 3'd1;
  localparam logic [2:0] FN_SLT  = 3'd2;
  localparam logic [2:0] FN_SLTU = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_SRL  = 3'd5;
  localparam logic [2:0] FN_OR   = 3'd6;
  localparam logic [2:0] FN_AND  = 3'd7;
  // Alternate functs (classes 001/011)
  localparam logic [2:0] FN_SUB  = 3'd0;
  localparam logic [2:0] FN_SRA  = 3'd5;
  // Branch compare functs (class 100)
  localparam logic [2:0] BR_EQ   = 3'd0;
  localparam logic [2:0] BR_NE   = 3'd1;
  localparam logic [2:0] BR_LT   = 3'd4;
  localparam logic [2:0] BR_GE   = 3'd5;
  localparam logic [2:0] BR_LTU  = 3'd6;
  localparam logic [2:0] BR_GEU  = 3'd7;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } cdb_entry_t;

  // Immediate classes take operand B from issue_imm instead of issue_rs2.
  function automatic logic uses_imm(input logic [2:0] cls);
    return (cls == CLS_RI) || (cls == CLS_RISH);
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// alu_unit_if: RS issue bus plus CDB channel of the ALU endpoint.
//   master: reservation station / CDB arbiter side (drives issue_*, cdb_gnt)
//   slave : ALU side (consumes issue_*, cdb_gnt; drives cdb_ok/en/val)
interface alu_unit_if;
  import alu_pkg::*;

  logic              issue_ok;
  logic [OPT_W-1:0]  issue_opt;
  logic [DATA_W-1:0] issue_rs1;
  logic [DATA_W-1:0] issue_rs2;
  logic [DATA_W-1:0] issue_imm;
  logic [TAG_W-1:0]  issue_en;
  logic              cdb_gnt;
  logic              cdb_ok;
  logic [TAG_W-1:0]  cdb_en;
  logic [DATA_W-1:0] cdb_val;

  modport master (
    output issue_ok, issue_opt, issue_rs1, issue_rs2, issue_imm, issue_en, cdb_gnt,
    input  cdb_ok, cdb_en, cdb_val
  );

  modport slave (
    input  issue_ok, issue_opt, issue_rs1, issue_rs2, issue_imm, issue_en, cdb_gnt,
    output cdb_ok, cdb_en, cdb_val
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: purely combinational integer datapath.
//   opt_i    [5:0]  class [5:3] / funct [2:0]
//   a_i      [31:0] operand A
//   b_i      [31:0] operand B (already selected between rs2 and imm)
//   result_o [31:0] result; unsupported class/funct combinations give 0
module alu_core
  import alu_pkg::*;
(
  input  logic [OPT_W-1:0]  opt_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  alu_cls_e          cls_s;
  logic [2:0]        fn_s;
  logic [4:0]        shamt_s;
  logic              lt_s;
  logic              ltu_s;
  logic              taken_s;
  logic [DATA_W-1:0] sra_s;

  assign cls_s   = alu_cls_e'(opt_i[5:3]);
  assign fn_s    = opt_i[2:0];
  assign shamt_s = b_i[4:0];
  assign lt_s    = $signed(a_i) < $signed(b_i);
  assign ltu_s   = a_i < b_i;
  assign sra_s   = DATA_W'($signed(a_i) >>> shamt_s);

  // Branch-taken decision; functs 2/3 are not defined and never take.
  always_comb begin
    taken_s = 1'b0;
    case (fn_s)
      BR_EQ:   taken_s = (a_i == b_i);
      BR_NE:   taken_s = (a_i != b_i);
      BR_LT:   taken_s = lt_s;
      BR_GE:   taken_s = !lt_s;
      BR_LTU:  taken_s = ltu_s;
      BR_GEU:  taken_s = !ltu_s;
      default: taken_s = 1'b0;
    endcase
  end

  // Result select by class, then funct.
  always_comb begin
    result_o = {DATA_W{1'b0}};
    case (cls_s)
      CLS_RR, CLS_RI: begin
        case (fn_s)
          FN_ADD:  result_o = a_i + b_i;
          FN_SLL:  result_o = a_i << shamt_s;
          FN_SLT:  result_o = {{(DATA_W-1){1'b0}}, lt_s};
          FN_SLTU: result_o = {{(DATA_W-1){1'b0}}, ltu_s};
          FN_XOR:  result_o = a_i ^ b_i;
          FN_SRL:  result_o = a_i >> shamt_s;
          FN_OR:   result_o = a_i | b_i;
          FN_AND:  result_o = a_i & b_i;
          default: result_o = {DATA_W{1'b0}};
        endcase
      end
      CLS_RSUB: begin
        case (fn_s)
          FN_SUB:  result_o = a_i - b_i;
          FN_SRA:  result_o = sra_s;
          default: result_o = {DATA_W{1'b0}};
        endcase
      end
      CLS_RISH: begin
        case (fn_s)
          FN_SRA:  result_o = sra_s;
          default: result_o = {DATA_W{1'b0}};
        endcase
      end
      CLS_BR:  result_o = {{(DATA_W-1){1'b0}}, taken_s};
      default: result_o = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with extra-MSB pointers.
//   clk, rst_n       clock, async active-low reset (storage cleared too)
//   en_i             global enable; low freezes every register
//   clr_i            synchronous flush, wins over push/pop; keeps overflow
//   push_i, data_i   write request/data; push at full succeeds only with a pop
//   pop_i            read request; ignored when empty
//   data_o           head entry (registered storage)
//   empty_o          FIFO empty
//   count_next_o     occupancy after the coming edge
//   overflow_o       sticky: a push was dropped at full
module sync_fifo #(
  parameter  int WIDTH = 36,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [AW:0]      count_next_o,
  output logic             overflow_o
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full_s, do_pop_s, do_push_s, drop_s, wr_en_s;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // Full: same slot index, opposite lap.
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Request qualification; a simultaneous pop frees the slot a full push needs.
  always_comb begin
    do_pop_s  = pop_i && !empty_o;
    do_push_s = push_i && (!full_s || do_pop_s);
    drop_s    = push_i && full_s && !do_pop_s;
  end

  // Next-state for pointers and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    wr_en_s  = 1'b0;
    if (!en_i) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
    end else if (clr_i) begin
      wr_ptr_d = {(AW+1){1'b0}};
      rd_ptr_d = {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        wr_en_s  = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      ovf_d = ovf_q | drop_s;
    end
  end

  assign count_next_o = wr_ptr_d - rd_ptr_d;
  assign overflow_o   = ovf_q;
  assign data_o       = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: ALU execution endpoint between the reservation station and CDB port 1.
//   clk, rst_n  clock, async active-low reset
//   rdy         global enable; low freezes state and holds outputs
//   clear       synchronous flush (mispredict); drops queued and same-cycle results
//   bus         alu_unit_if.slave: issue_* in, cdb_gnt in, cdb_ok/en/val out
//   alu_stall   registered: occupancy >= STALL_TH
//   overflow    sticky: an issued result was dropped at full
// Each accepted issue is computed combinationally and queued; the CDB shows
// the queue head and pops it on cdb_gnt.
module alu_unit
  import alu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int STALL_TH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       clear,
  alu_unit_if.slave  bus,
  output logic       alu_stall,
  output logic       overflow
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] STALL_TH_W = (AW+1)'(STALL_TH);

  logic [DATA_W-1:0] opb_s;
  logic [DATA_W-1:0] res_s;
  cdb_entry_t        push_s;
  cdb_entry_t        head_s;
  logic              empty_s;
  logic [AW:0]       cnt_next_s;
  logic              stall_q, stall_d;

  assign opb_s = uses_imm(bus.issue_opt[5:3]) ? bus.issue_imm : bus.issue_rs2;

  alu_core u_core (
    .opt_i    (bus.issue_opt),
    .a_i      (bus.issue_rs1),
    .b_i      (opb_s),
    .result_o (res_s)
  );

  assign push_s.tag = bus.issue_en;
  assign push_s.val = res_s;

  sync_fifo #(
    .WIDTH ($bits(cdb_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (rdy),
    .clr_i        (clear),
    .push_i       (bus.issue_ok),
    .data_i       (push_s),
    .pop_i        (bus.cdb_gnt),
    .data_o       (head_s),
    .empty_o      (empty_s),
    .count_next_o (cnt_next_s),
    .overflow_o   (overflow)
  );

  // Stall flag follows the occupancy the FIFO will hold after this edge.
  always_comb begin
    if (rdy) begin
      stall_d = (cnt_next_s >= STALL_TH_W);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign alu_stall   = stall_q;
  // Head fields are masked when empty so stale storage never shows on the CDB.
  assign bus.cdb_ok  = !empty_s;
  assign bus.cdb_en  = empty_s ? {TAG_W{1'b0}}  : head_s.tag;
  assign bus.cdb_val = empty_s ? {DATA_W{1'b0}} : head_s.val;

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Execution-side endpoint of the RS issue interface: consumes one issued op per cycle (ok/opt/rs1/rs2/imm/ROB tag) and computes the integer result.
- Queues results in a 4-entry result FIFO and broadcasts them on one CDB channel (ok/en/val) under an arbiter grant.
- Sits between the reservation station and CDB port 1. It also provides an early-stall output for future RS flow control.

Parameters:
- DEPTH, 4, result FIFO entries (power of two, >=2)
- STALL_TH, 3, occupancy at/above which alu_stall asserts

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low = freeze all state, ignore issue, hold outputs
- clear  in  1  synchronous flush (mispredict)
- issue_ok  in  1  issue valid (no back-pressure; must be accepted)
- issue_opt  in  6  opcode: [5:3] class, [2:0] funct
- issue_rs1  in  32  operand A
- issue_rs2  in  32  operand B (register classes)
- issue_imm  in  32  operand B (immediate classes 010/011)
- issue_en  in  4  ROB tag
- cdb_gnt  in  1  arbiter grant for current head
- cdb_ok  out  1  result valid
- cdb_en  out  4  ROB tag of result
- cdb_val  out  32  result value
- alu_stall  out  1  occupancy >= STALL_TH
- overflow  out  1  sticky: push dropped at full

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, cdb_ok=0, cdb_en=0, cdb_val=0, alu_stall=0, overflow=0. Reset mid-operation discards all entries.
- Class 000 (rs1 op rs2) and 010 (rs1 op imm), funct: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
- Class 001 (R only): funct 0 SUB, funct 5 SRA. Class 011 (imm): funct 5 SRAI. Other funct in 001/011: result 0.
- Class 100 (branch compare rs1 vs rs2): funct 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU. Result is 32'd1 if taken, else 0. funct 2/3: result 0.
- Classes 101..111: result 0, still broadcast with the tag.
- Arithmetic: 32-bit wrap-around. Shift amount = operand B [4:0]. Signed compares use two's complement.
- Latency: issue sampled at edge T (result computed combinationally, pushed into FIFO). Earliest cdb_ok=1 is the cycle after T.
- Outputs are the FIFO head, registered storage, no combinational path from issue. cdb_ok = FIFO non-empty.
- Pop at edge where cdb_ok && cdb_gnt. Head must hold stable while cdb_ok && !cdb_gnt.
- Ordering: strict FIFO, results broadcast in issue order.
- Simultaneous push and pop: allowed at any occupancy including full, so occupancy is unchanged.
- Push at full without pop: entry dropped, overflow set until reset. clear does not reset overflow.
- Empty with cdb_gnt: no effect.
- clear=1: FIFO emptied at that edge, cdb_ok=0 next cycle. Issue in the same cycle is discarded. Clear has priority over push/pop.
- rdy=0: no push, no pop, no pointer change. Outputs held; cdb_gnt ignored. rst_n still overrides.
- Pointers are log2(DEPTH)+1 bits. Full = MSB differs and index bits equal. Wrap-around is natural modulo.
- alu_stall is a registered function of occupancy after the edge.

Decomposition:
- Shared package alu_pkg:
  - class codes CLS_RR=3'b000, CLS_RSUB=3'b001, CLS_RI=3'b010, CLS_RISH=3'b011, CLS_BR=3'b100
  - funct codes
  - ROB tag width 4
  - RS "no-dependency" tag value 16 (5-bit)
- Sub-module alu_core: purely combinational (opt, a, b) -> 32-bit result.
- The FIFO is instantiated as a generic sync_fifo.

Test Plan:
- Reset then issue ADD (opt 000_000, rs1=5, rs2=7, en=3) with cdb_gnt=1 -> next cycle cdb_ok=1, cdb_en=3, cdb_val=12; following cycle cdb_ok=0.
- SRAI (opt 011_101, rs1=32'h8000_0000, imm=4) and BLTU (100_110, rs1=1, rs2=32'hFFFF_FFFF) -> vals 32'hF800_0000 then 1, in order.
- cdb_gnt=0, issue 4 ops (tags 1..4) -> alu_stall=1 after the 3rd. Then 5th issue -> overflow=1. Then gnt=1 gives tags 1,2,3,4 in order, each held until granted.
- FIFO full, same-cycle issue (tag 9) and gnt -> occupancy stays 4, overflow stays 0, tag 9 broadcast last.
- 2 entries queued, assert clear with concurrent issue -> cdb_ok=0 next cycle, no tags ever broadcast.
- rdy=0 for 3 cycles with entries queued and gnt=1 -> outputs frozen. rst_n pulsed low asynchronously mid-cycle -> cdb_ok=0 immediately, before the next edge.
